// File: rtl/muldiv_if.sv
// Connection between the mul/div sequencer and the shared multiplier and divider.
// master = sequencer, slave = arithmetic units.
interface muldiv_if;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_annul;
  logic        div_ready;
  logic [63:0] div_result;

  modport master (
    output mul_signed, mul_a, mul_b,
    input  mul_result,
    output div_start, div_signed, div_a, div_b, div_annul,
    input  div_ready, div_result
  );

  modport slave (
    input  mul_signed, mul_a, mul_b,
    output mul_result,
    input  div_start, div_signed, div_a, div_b, div_annul,
    output div_ready, div_result
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the pipelined multiplier and the iterative divider.
// It stalls EX while an operation runs, then holds a one-shot HI/LO write until EX advances.
//
//   state    | meaning
//   IDLE     | no operation; operands pass straight through from src1/src2
//   MUL_WAIT | down-counting the fixed multiplier latency
//   DIV_WAIT | divider started, waiting for div_ready
//   DONE     | HI/LO write presented, held while pipe_hold
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        pipe_hold,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  muldiv_if.master    au,
  output logic        stallreq,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] busy_cycles
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] a_q, b_q;
  logic        sgn_q;
  logic        op_mul, op_div, op_sgn, accept, idle;
  logic        ld_res;
  logic [31:0] hi_nxt, lo_nxt;
  logic        div_start, div_annul;

  // Multi-bit op codes decode to nothing, so they are never accepted.
  assign op_mul = (op == 4'b1000) || (op == 4'b0100);
  assign op_div = (op == 4'b0010) || (op == 4'b0001);
  assign op_sgn = (op == 4'b1000) || (op == 4'b0010);
  assign idle   = (state == IDLE);
  assign accept = idle && op_valid && (op_mul || op_div) && !flush;

  assign au.mul_a      = idle ? src1 : a_q;
  assign au.mul_b      = idle ? src2 : b_q;
  assign au.div_a      = idle ? src1 : a_q;
  assign au.div_b      = idle ? src2 : b_q;
  assign au.mul_signed = idle ? op_sgn : sgn_q;
  assign au.div_signed = idle ? op_sgn : sgn_q;
  assign au.div_start  = div_start;
  assign au.div_annul  = div_annul;

  assign stallreq = accept || (state == MUL_WAIT) || (state == DIV_WAIT);
  assign hi_we    = (state == DONE) && !flush;
  assign lo_we    = (state == DONE) && !flush;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_res    = 1'b0;
    hi_nxt    = hi_o;
    lo_nxt    = lo_o;
    div_start = 1'b0;
    div_annul = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      div_annul = (state == DIV_WAIT);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_mul) begin
              cnt_nxt   = 4'(MUL_LAT - 1);
              state_nxt = MUL_WAIT;
            end else if (src2 != 32'd0) begin
              div_start = 1'b1;
              state_nxt = DIV_WAIT;
            end else begin
              // Divide by zero bypasses the divider with a fixed result.
              ld_res    = 1'b1;
              hi_nxt    = src1;
              lo_nxt    = '1;
              state_nxt = DONE;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
          end else begin
            ld_res    = 1'b1;
            hi_nxt    = au.mul_result[63:32];
            lo_nxt    = au.mul_result[31:0];
            state_nxt = DONE;
          end
        end
        DIV_WAIT: begin
          if (au.div_ready) begin
            ld_res    = 1'b1;
            hi_nxt    = au.div_result[63:32];
            lo_nxt    = au.div_result[31:0];
            state_nxt = DONE;
          end else begin
            div_start = 1'b1;
          end
        end
        DONE: begin
          if (!pipe_hold) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      sgn_q       <= 1'b0;
      hi_o        <= 32'd0;
      lo_o        <= 32'd0;
      busy_cycles <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        a_q   <= src1;
        b_q   <= src2;
        sgn_q <= op_sgn;
      end
      if (ld_res) begin
        hi_o <= hi_nxt;
        lo_o <= lo_nxt;
      end
      if (stallreq && (busy_cycles != 32'hFFFF_FFFF)) busy_cycles <= busy_cycles + 32'd1;
    end
  end

endmodule
